l2_set_rd_buf: RTL and testbench
================================

Name: l2_set_rd_buf

Overview:
- Multi-entry, parametrised successor to the single-snapshot L2 read buffer.
- Captures one full-set read (all ways: line, tag, hprot, state, plus the eviction way) per enabled cycle into a DEPTH-deep FIFO, so the lookup pipeline can keep issuing reads while the controller drains snapshots at its own pace.
- Snoops L2 writes and patches buffered snapshots of the same set, so no drained snapshot is stale.
- Precomputes a per-entry tag hit vector.
- Sits between the L2 tag/data SRAM read ports and the L2 controller FSM.

Parameters:
- WAYS, 8, ways per set; a power of 2, at least 2.
- DEPTH, 4, FIFO entries; a power of 2, at least 2.
- SET_W, 9, set index width.
- TAG_W, 20, tag width.
- LINE_W, 128, line width.
- STATE_W, 3, state width.
- HPROT_W, 1, hprot width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- rd_mem_en  in  1  push: capture the rd_* inputs this cycle.
- rd_ready  out  1  equals !full.
- rd_set  in  SET_W  set index of the read.
- rd_req_tag  in  TAG_W  requested tag, used for hit computation.
- rd_data_line  in  WAYS*LINE_W  per-way lines.
- rd_data_tag  in  WAYS*TAG_W  per-way tags.
- rd_data_hprot  in  WAYS*HPROT_W  per-way hprot.
- rd_data_state  in  WAYS*STATE_W  per-way state.
- rd_data_evict_way  in  log2(WAYS)  eviction way.
- wr_en  in  1  L2 array write this cycle.
- wr_set  in  SET_W  set index of the write.
- wr_way  in  log2(WAYS)  way being written.
- wr_line  in  LINE_W  write data: line.
- wr_tag  in  TAG_W  write data: tag.
- wr_hprot  in  HPROT_W  write data: hprot.
- wr_state  in  STATE_W  write data: state.
- flush  in  1  synchronous clear of all entries.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  pop the head.
- set_buf  out  SET_W  head field: set index.
- evict_way_buf  out  log2(WAYS)  head field: eviction way.
- lines_buf  out  WAYS*LINE_W  head field: lines.
- tags_buf  out  WAYS*TAG_W  head field: tags.
- hprots_buf  out  WAYS*HPROT_W  head field: hprot.
- states_buf  out  WAYS*STATE_W  head field: states.
- hit_buf  out  WAYS  head field: per-way hit bits.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst low):
  - rd/wr pointers = 0, count = 0, out_valid = 0.
  - All head outputs read as 0.
  - All entry storage = 0.
  - Reset asserted mid-operation discards all entries immediately.
- Push:
  - Occurs when rd_mem_en && rd_ready.
  - The entry is written at wr_ptr on the clock edge.
  - hit[w] = (rd_data_tag[w] == rd_req_tag) && (rd_data_state[w] != 0), with state 0 = INVALID.
- rd_mem_en while full:
  - Ignored: no state change.
  - Simulation assertion fires.
- Pop:
  - Occurs when out_valid && out_ready.
  - rd_ptr advances.
- Pointers: log2(DEPTH) bits, natural wrap. full = (count == DEPTH); empty = (count == 0).
- Latency (no bypass): a push in cycle N makes out_valid = 1 in cycle N+1. Head fields are driven directly from storage.
- Simultaneous push and pop:
  - Allowed whenever not full and not empty.
  - count is unchanged.
- Write snoop: in each cycle with wr_en, every valid entry whose set == wr_set has way wr_way overwritten with the wr_* fields. That entry's hit[wr_way] is recomputed against the entry's stored req_tag (each entry stores req_tag).
- Same-set push and write in the same cycle: the pushed entry takes the wr_* fields for wr_way (write wins over the SRAM read data).
- Write to the head entry while it is popped in the same cycle: the update is lost along with the popped entry. No error.
- evict_way is never modified by a snoop.
- flush:
  - On the next edge: count = 0, pointers = 0, out_valid = 0.
  - Any same-cycle push or pop is ignored.
  - Priority: reset > flush > push/pop/snoop.

Optional Feature:
- Macro: L2_SET_BUF_BYPASS_EN.
- Defined: when empty && rd_mem_en, out_valid = 1 combinationally in the same cycle.
  - Head outputs show rd_* merged with any same-cycle snoop.
  - If out_ready is also high, nothing is stored.
  - rd_ready is unchanged.
- Undefined: fixed 1-cycle latency; no combinational path from rd_* to the outputs.

Decomposition:
- Shared package spandex_types:
  - Existing typedefs: line_t, l2_tag_t, hprot_t, state_t, l2_way_t, l2_set_t.
  - New struct l2_set_snap_t: set, req_tag, evict_way, lines, tags, hprots, states, hit.
  - Constant INVALID = 0.
- Sub-module l2_set_snap_entry: one entry's storage, snoop-merge and hit recompute, instantiated DEPTH times. The top level holds the pointers, count, flush and bypass muxing.

Test Plan:
- Push 4 reads (sets 1,2,3,4), out_ready = 0:
  - count = 4, rd_ready = 0.
  - A 5th rd_mem_en is ignored.
  - Draining yields sets 1,2,3,4 in order.
- Push set 5 with rd_req_tag = 0xABC, tag[way 3] = 0xABC, state[3] = 2 → hit_buf = 8'b0000_1000 next cycle.
- Buffer sets 7 and 9, then wr_en with set 7, way 2, line = 0x55.., state = 0 → drained set-7 entry shows line[2] = 0x55.. and hit[2] = 0; the set-9 entry is unchanged.
- Push set 6 and write set 6 way 0 (tag 0x1) in the same cycle → buffered tags[0] = 0x1.
- Push/pop every cycle for 20 cycles with count = 2 → count stays 2; pointers wrap correctly.
- Fill 3 entries, then flush → out_valid = 0, count = 0.
  - Drop rst mid-stream → all outputs 0 asynchronously.
  - With L2_SET_BUF_BYPASS_EN: a push into the empty buffer shows out_valid in the same cycle.

Source files
------------

// File: rtl/spandex_types.sv
// spandex_types: shared L2 type definitions and the buffered set snapshot record.
package spandex_types;
    localparam int L2_WAYS           = 8;
    localparam int L2_WAY_BITS       = $clog2(L2_WAYS);
    localparam int L2_SET_BITS       = 9;
    localparam int L2_TAG_BITS       = 20;
    localparam int BITS_PER_LINE     = 128;
    localparam int STABLE_STATE_BITS = 3;
    localparam int HPROT_WIDTH       = 1;

    typedef logic [BITS_PER_LINE-1:0]     line_t;
    typedef logic [L2_TAG_BITS-1:0]       l2_tag_t;
    typedef logic [HPROT_WIDTH-1:0]       hprot_t;
    typedef logic [STABLE_STATE_BITS-1:0] state_t;
    typedef logic [L2_WAY_BITS-1:0]       l2_way_t;
    typedef logic [L2_SET_BITS-1:0]       l2_set_t;

    typedef struct packed {
        l2_set_t                   set;
        l2_tag_t                   req_tag;
        l2_way_t                   evict_way;
        line_t  [L2_WAYS-1:0]      lines;
        l2_tag_t [L2_WAYS-1:0]     tags;
        hprot_t [L2_WAYS-1:0]      hprots;
        state_t [L2_WAYS-1:0]      states;
        logic   [L2_WAYS-1:0]      hit;
    } l2_set_snap_t;

    localparam state_t INVALID = '0;
endpackage

// File: rtl/l2_set_snap_entry.sv
// l2_set_snap_entry: one set snapshot slot; merges same-set L2 writes and keeps its hit vector current.
module l2_set_snap_entry
    import spandex_types::*;
#(
    parameter int WAYS    = L2_WAYS,
    parameter int SET_W   = L2_SET_BITS,
    parameter int TAG_W   = L2_TAG_BITS,
    parameter int LINE_W  = BITS_PER_LINE,
    parameter int STATE_W = STABLE_STATE_BITS,
    parameter int HPROT_W = HPROT_WIDTH,
    parameter int WW      = $clog2(WAYS),
    parameter int OUT_W   = SET_W + WW + WAYS * (LINE_W + TAG_W + HPROT_W + STATE_W + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        sel,
    input  logic                        load,
    input  logic                        pop,
    input  logic [OUT_W+TAG_W-WAYS-1:0] rd_snap,
    input  logic                        wr_en,
    input  logic [SET_W-1:0]            wr_set,
    input  logic [WW-1:0]               wr_way,
    input  logic [LINE_W-1:0]           wr_line,
    input  logic [TAG_W-1:0]            wr_tag,
    input  logic [HPROT_W-1:0]          wr_hprot,
    input  logic [STATE_W-1:0]          wr_state,
    output logic [OUT_W-1:0]            q,
    output logic [OUT_W-1:0]            nxt
);
    typedef struct packed {
        logic [SET_W-1:0]              set;
        logic [TAG_W-1:0]              req_tag;
        logic [WW-1:0]                 evict_way;
        logic [WAYS-1:0][LINE_W-1:0]   lines;
        logic [WAYS-1:0][TAG_W-1:0]    tags;
        logic [WAYS-1:0][HPROT_W-1:0]  hprots;
        logic [WAYS-1:0][STATE_W-1:0]  states;
        logic [WAYS-1:0]               hit;
    } snap_t;

    snap_t st, base, mrg;
    logic  vld;

    // sel picks the incoming SRAM read as the merge base so a same-cycle write wins over it
    always_comb begin
        base = sel ? snap_t'({rd_snap, {WAYS{1'b0}}}) : st;
        mrg  = base;
        if (wr_en && (sel || vld) && base.set == wr_set) begin
            mrg.lines[wr_way]  = wr_line;
            mrg.tags[wr_way]   = wr_tag;
            mrg.hprots[wr_way] = wr_hprot;
            mrg.states[wr_way] = wr_state;
        end
        for (int w = 0; w < WAYS; w++)
            mrg.hit[w] = mrg.tags[w] == mrg.req_tag && mrg.states[w] != STATE_W'(INVALID);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= '0;
            vld <= 1'b0;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (load) begin
            st  <= mrg;
            vld <= 1'b1;
        end else begin
            if (vld && !pop) st <= mrg;
            vld <= vld && !pop;
        end
    end

    assign q   = {st.set, st.evict_way, st.lines, st.tags, st.hprots, st.states, st.hit};
    assign nxt = {mrg.set, mrg.evict_way, mrg.lines, mrg.tags, mrg.hprots, mrg.states, mrg.hit};
endmodule

// File: rtl/l2_set_rd_buf.sv
// l2_set_rd_buf: DEPTH-deep FIFO of full-set L2 read snapshots with write snoop and tag hit vector.
// Define L2_SET_BUF_BYPASS_EN to present a push into the empty buffer on the outputs in the same cycle.
module l2_set_rd_buf
    import spandex_types::*;
#(
    parameter int WAYS    = L2_WAYS,
    parameter int DEPTH   = 4,
    parameter int SET_W   = L2_SET_BITS,
    parameter int TAG_W   = L2_TAG_BITS,
    parameter int LINE_W  = BITS_PER_LINE,
    parameter int STATE_W = STABLE_STATE_BITS,
    parameter int HPROT_W = HPROT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_mem_en,
    output logic                        rd_ready,
    input  logic [SET_W-1:0]            rd_set,
    input  logic [TAG_W-1:0]            rd_req_tag,
    input  logic [WAYS*LINE_W-1:0]      rd_data_line,
    input  logic [WAYS*TAG_W-1:0]       rd_data_tag,
    input  logic [WAYS*HPROT_W-1:0]     rd_data_hprot,
    input  logic [WAYS*STATE_W-1:0]     rd_data_state,
    input  logic [$clog2(WAYS)-1:0]     rd_data_evict_way,
    input  logic                        wr_en,
    input  logic [SET_W-1:0]            wr_set,
    input  logic [$clog2(WAYS)-1:0]     wr_way,
    input  logic [LINE_W-1:0]           wr_line,
    input  logic [TAG_W-1:0]            wr_tag,
    input  logic [HPROT_W-1:0]          wr_hprot,
    input  logic [STATE_W-1:0]          wr_state,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SET_W-1:0]            set_buf,
    output logic [$clog2(WAYS)-1:0]     evict_way_buf,
    output logic [WAYS*LINE_W-1:0]      lines_buf,
    output logic [WAYS*TAG_W-1:0]       tags_buf,
    output logic [WAYS*HPROT_W-1:0]     hprots_buf,
    output logic [WAYS*STATE_W-1:0]     states_buf,
    output logic [WAYS-1:0]             hit_buf,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int WW    = $clog2(WAYS);
    localparam int PW    = $clog2(DEPTH);
    localparam int OUT_W = SET_W + WW + WAYS * (LINE_W + TAG_W + HPROT_W + STATE_W + 1);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, empty, push_req, push, pop, byp;
    logic [OUT_W-1:0] q_v [DEPTH];
    logic [OUT_W-1:0] nxt_v [DEPTH];

    assign full     = count == (PW+1)'(DEPTH);
    assign empty    = count == '0;
    assign rd_ready = !full;
    assign push_req = rd_mem_en && !full;
`ifdef L2_SET_BUF_BYPASS_EN
    assign byp = empty && rd_mem_en;
`else
    assign byp = 1'b0;
`endif
    // a bypassed read consumed in the same cycle never occupies an entry
    assign push      = push_req && !(byp && out_ready);
    assign pop       = !empty && out_ready;
    assign out_valid = !empty || byp;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        l2_set_snap_entry #(
            .WAYS(WAYS), .SET_W(SET_W), .TAG_W(TAG_W), .LINE_W(LINE_W),
            .STATE_W(STATE_W), .HPROT_W(HPROT_W)
        ) u_ent (
            .clk      (clk),
            .rst      (rst),
            .clr      (flush),
            .sel      (push_req && wr_ptr == PW'(i)),
            .load     (push && wr_ptr == PW'(i)),
            .pop      (pop && rd_ptr == PW'(i)),
            .rd_snap  ({rd_set, rd_req_tag, rd_data_evict_way, rd_data_line, rd_data_tag,
                        rd_data_hprot, rd_data_state}),
            .wr_en    (wr_en),
            .wr_set   (wr_set),
            .wr_way   (wr_way),
            .wr_line  (wr_line),
            .wr_tag   (wr_tag),
            .wr_hprot (wr_hprot),
            .wr_state (wr_state),
            .q        (q_v[i]),
            .nxt      (nxt_v[i])
        );
    end

    assign {set_buf, evict_way_buf, lines_buf, tags_buf, hprots_buf, states_buf, hit_buf} =
        byp ? nxt_v[wr_ptr] : q_v[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always @(posedge clk)
        if (rst && rd_mem_en) assert (!full) else $warning("rd_mem_en while full is ignored");
endmodule

// File: tb/tb_l2_set_rd_buf.sv
// tb_l2_set_rd_buf: directed scenario tasks with inline checks for the L2 set snapshot FIFO.
module tb_l2_set_rd_buf;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd_mem_en = 1'b0, rd_ready;
    logic [8:0]   rd_set = '0;
    logic [19:0]  rd_req_tag = '0;
    logic [1023:0] rd_data_line = '0;
    logic [159:0] rd_data_tag = '0;
    logic [7:0]   rd_data_hprot = '0;
    logic [23:0]  rd_data_state = '0;
    logic [2:0]   rd_data_evict_way = '0;
    logic         wr_en = 1'b0;
    logic [8:0]   wr_set = '0;
    logic [2:0]   wr_way = '0;
    logic [127:0] wr_line = '0;
    logic [19:0]  wr_tag = '0;
    logic [0:0]   wr_hprot = '0;
    logic [2:0]   wr_state = '0;
    logic         flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [8:0]   set_buf;
    logic [2:0]   evict_way_buf;
    logic [1023:0] lines_buf;
    logic [159:0] tags_buf;
    logic [7:0]   hprots_buf;
    logic [23:0]  states_buf;
    logic [7:0]   hit_buf;
    logic [2:0]   count;
    int           pass_cnt = 0, chk_cnt = 0;

    l2_set_rd_buf dut (
        .clk(clk), .rst(rst), .rd_mem_en(rd_mem_en), .rd_ready(rd_ready), .rd_set(rd_set),
        .rd_req_tag(rd_req_tag), .rd_data_line(rd_data_line), .rd_data_tag(rd_data_tag),
        .rd_data_hprot(rd_data_hprot), .rd_data_state(rd_data_state),
        .rd_data_evict_way(rd_data_evict_way), .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way),
        .wr_line(wr_line), .wr_tag(wr_tag), .wr_hprot(wr_hprot), .wr_state(wr_state),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .set_buf(set_buf),
        .evict_way_buf(evict_way_buf), .lines_buf(lines_buf), .tags_buf(tags_buf),
        .hprots_buf(hprots_buf), .states_buf(states_buf), .hit_buf(hit_buf), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // way w of set s: line = {s, w}, tag = {s, w[3:0]}
    task automatic drive_rd(input logic [8:0] s, input logic [19:0] rt, input logic [23:0] st,
                            input logic [2:0] ev);
        rd_mem_en = 1'b1;
        rd_set = s;
        rd_req_tag = rt;
        rd_data_state = st;
        rd_data_evict_way = ev;
        rd_data_hprot = '0;
        for (int w = 0; w < 8; w++) begin
            rd_data_line[w*128 +: 128] = 128'({s, w[7:0]});
            rd_data_tag[w*20 +: 20] = {7'd0, s, w[3:0]};
        end
    endtask

    task automatic idle();
        rd_mem_en = 1'b0;
        wr_en = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
        chk_cnt++; if (rd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", rd_ready); else pass_cnt++;
        chk_cnt++; if (lines_buf !== '0 || set_buf !== '0 || hit_buf !== '0)
            $display("FAIL reset_head got set %0d hit %h want 0", set_buf, hit_buf); else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            drive_rd(9'(i), 20'h0, 24'h0, 3'(i));
            step();
        end
        idle();
        chk_cnt++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else pass_cnt++;
        chk_cnt++; if (rd_ready !== 1'b0) $display("FAIL fill_ready got %b want 0", rd_ready); else pass_cnt++;
        drive_rd(9'd5, 20'h0, 24'h0, 3'd5);
        step();
        idle();
        chk_cnt++; if (count !== 3'd4 || set_buf !== 9'd1)
            $display("FAIL full_push got count %0d head %0d want 4 1", count, set_buf); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk_cnt++; if (out_valid !== 1'b1 || set_buf !== 9'(i) || evict_way_buf !== 3'(i))
                $display("FAIL drain_order got v %b set %0d ev %0d want 1 %0d %0d", out_valid, set_buf, evict_way_buf, i, i);
            else pass_cnt++;
            step();
        end
        idle();
        chk_cnt++; if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL drain_empty got count %0d v %b want 0 0", count, out_valid); else pass_cnt++;
    endtask

    task automatic test_hit();
        drive_rd(9'd5, 20'hABC, 24'h000400, 3'd0);
        rd_data_tag[3*20 +: 20] = 20'hABC;
        rd_data_tag[5*20 +: 20] = 20'hABC;
        #1;
`ifdef L2_SET_BUF_BYPASS_EN
        chk_cnt++; if (out_valid !== 1'b1 || set_buf !== 9'd5 || hit_buf !== 8'h08)
            $display("FAIL bypass got v %b set %0d hit %h want 1 5 08", out_valid, set_buf, hit_buf); else pass_cnt++;
`else
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL latency got v %b want 0", out_valid); else pass_cnt++;
`endif
        step();
        idle();
        chk_cnt++; if (out_valid !== 1'b1 || hit_buf !== 8'b0000_1000)
            $display("FAIL hit_vec got v %b hit %b want 1 00001000", out_valid, hit_buf); else pass_cnt++;
        out_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_snoop();
        drive_rd(9'd7, 20'h72, 24'h249249, 3'd3);
        step();
        drive_rd(9'd9, 20'h0, 24'h249249, 3'd1);
        step();
        idle();
        chk_cnt++; if (set_buf !== 9'd7 || hit_buf !== 8'h04)
            $display("FAIL snoop_pre got set %0d hit %h want 7 04", set_buf, hit_buf); else pass_cnt++;
        wr_en = 1'b1; wr_set = 9'd7; wr_way = 3'd2; wr_line = {16{8'h55}};
        wr_tag = 20'h72; wr_state = 3'd0; wr_hprot = 1'b1;
        step();
        idle();
        chk_cnt++; if (lines_buf[256 +: 128] !== {16{8'h55}} || hit_buf !== 8'h00)
            $display("FAIL snoop_patch got line %h hit %h want 55.. 00", lines_buf[256 +: 128], hit_buf); else pass_cnt++;
        chk_cnt++; if (hprots_buf[2] !== 1'b1 || states_buf[8:6] !== 3'd0 || evict_way_buf !== 3'd3)
            $display("FAIL snoop_fields got hp %b st %0d ev %0d want 1 0 3", hprots_buf[2], states_buf[8:6], evict_way_buf);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        idle();
        chk_cnt++; if (set_buf !== 9'd9 || lines_buf[256 +: 128] !== 128'({9'd9, 8'd2}) || tags_buf[40 +: 20] !== 20'h92)
            $display("FAIL snoop_other got set %0d line %h tag %h want 9 902 92", set_buf, lines_buf[256 +: 128], tags_buf[40 +: 20]);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_push_write();
        drive_rd(9'd6, 20'h1, 24'h0, 3'd0);
        wr_en = 1'b1; wr_set = 9'd6; wr_way = 3'd0; wr_line = '0;
        wr_tag = 20'h1; wr_state = 3'd3; wr_hprot = 1'b0;
        step();
        idle();
        chk_cnt++; if (tags_buf[19:0] !== 20'h1 || states_buf[2:0] !== 3'd3 || hit_buf !== 8'h01)
            $display("FAIL push_write got tag %h st %0d hit %h want 1 3 01", tags_buf[19:0], states_buf[2:0], hit_buf);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        drive_rd(9'd10, 20'h0, 24'h0, 3'd0);
        step();
        drive_rd(9'd11, 20'h0, 24'h0, 3'd0);
        step();
        for (int k = 0; k < 20; k++) begin
            drive_rd(9'(12 + k), 20'h0, 24'h0, 3'd0);
            out_ready = 1'b1;
            chk_cnt++; if (count !== 3'd2 || set_buf !== 9'(10 + k))
                $display("FAIL b2b got count %0d head %0d want 2 %0d", count, set_buf, 10 + k); else pass_cnt++;
            step();
        end
        idle();
        out_ready = 1'b1;
        for (int k = 30; k <= 31; k++) begin
            chk_cnt++; if (set_buf !== 9'(k) || out_valid !== 1'b1)
                $display("FAIL b2b_tail got head %0d v %b want %0d 1", set_buf, out_valid, k); else pass_cnt++;
            step();
        end
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive_rd(9'(40 + i), 20'h0, 24'h0, 3'd0);
            step();
        end
        idle();
        chk_cnt++; if (count !== 3'd3) $display("FAIL flush_pre got count %0d want 3", count); else pass_cnt++;
        flush = 1'b1;
        drive_rd(9'd50, 20'h0, 24'h0, 3'd0);
        out_ready = 1'b1;
        step();
        idle();
        chk_cnt++; if (count !== 3'd0 || out_valid !== 1'b0 || rd_ready !== 1'b1)
            $display("FAIL flush got count %0d v %b rdy %b want 0 0 1", count, out_valid, rd_ready); else pass_cnt++;
        drive_rd(9'd20, 20'h0, 24'h0, 3'd0);
        step();
        idle();
        chk_cnt++; if (count !== 3'd1 || set_buf !== 9'd20)
            $display("FAIL flush_after got count %0d head %0d want 1 20", count, set_buf); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive_rd(9'd21, 20'h0, 24'h249249, 3'd5);
        step();
        idle();
        #1 rst = 1'b0;
        #1;
        chk_cnt++; if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL areset_ctl got count %0d v %b want 0 0", count, out_valid); else pass_cnt++;
        chk_cnt++; if (set_buf !== '0 || lines_buf !== '0 || tags_buf !== '0 || states_buf !== '0 || evict_way_buf !== '0)
            $display("FAIL areset_head got set %0d ev %0d want 0 0", set_buf, evict_way_buf); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_cnt++; if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL areset_hold got count %0d v %b want 0 0", count, out_valid); else pass_cnt++;
    endtask

    initial begin
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        test_fill_drain();
        test_hit();
        test_snoop();
        test_push_write();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
